// File: rtl/msg_pkg.sv
// Shared types and helpers for the message output buffer.
package msg_pkg;

  localparam int MSG_BYTES = 32;

  typedef logic [8*MSG_BYTES-1:0] msg_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HAVE  = 1'b1
  } out_state_t;

  // Saturating increment of a counter that is w bits wide, carried in 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/msg_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, asynchronous read index.
module msg_fifo_mem #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally left unreset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msg_out_buffer.sv
// Output FIFO after the message controller with valid/ready re-presentation and drop accounting.
// Optional statistics counters are compiled in with MSG_OUT_BUFFER_STATS_EN.
module msg_out_buffer
  import msg_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_WIDTH     = 16,
  localparam int W            = 8*MAX_MSG_BYTES,
  localparam int AW           = $clog2(DEPTH),
  localparam int PW           = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  msg_data,
  input  logic          msg_valid,
  input  logic          msg_error,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [W-1:0]  m_tdata,
  output logic [PW-1:0] fill_level,
  output logic          overflow,
  input  logic          overflow_clr
`ifdef MSG_OUT_BUFFER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] msg_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] drop_count
`endif
);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full;
  logic          wr_req, rd_fire, wr_acc, drop;
  logic [W-1:0]  rd_data;
  out_state_t    state_q, state_d;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_req     = msg_valid && !msg_error;
  assign rd_fire    = m_tvalid && m_tready;
  assign wr_acc     = wr_req && (!full || rd_fire);
  assign drop       = wr_req && full && !rd_fire;
  assign fill_level = wr_ptr - rd_ptr;

  msg_fifo_mem #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (msg_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      state_q  <= EMPTY;
    end else begin
      state_q <= state_d;
      if (wr_acc)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      // A drop in the same cycle as a clear must still be reported.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (wr_acc) state_d = HAVE;
      HAVE:  if (rd_fire && (fill_level == PW'(1)) && !wr_acc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign m_tvalid = (state_q == HAVE);
  // Unreset storage must not leak onto the bus while nothing is held.
  assign m_tdata  = m_tvalid ? rd_data : '0;

  a_state_matches_ptrs: assert property (@(posedge clk) disable iff (rst) m_tvalid == !empty);

`ifdef MSG_OUT_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_count  <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (wr_acc)    msg_count <= CNT_WIDTH'(sat_inc(32'(msg_count), CNT_WIDTH));
      if (msg_error) err_count <= CNT_WIDTH'(sat_inc(32'(err_count), CNT_WIDTH));
      if (drop)
        drop_count <= CNT_WIDTH'(sat_inc(overflow_clr ? 32'd0 : 32'(drop_count), CNT_WIDTH));
      else if (overflow_clr)
        drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_msg_out_buffer.sv
// Directed self-checking bench for msg_out_buffer (default parameters).
module tb_msg_out_buffer;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] msg_data;
  logic         msg_valid, msg_error;
  logic         m_tvalid;
  logic         m_tready;
  logic [W-1:0] m_tdata;
  logic [2:0]   fill_level;
  logic         overflow;
  logic         overflow_clr;
`ifdef MSG_OUT_BUFFER_STATS_EN
  logic [15:0]  msg_count, err_count, drop_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msg_out_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .msg_data     (msg_data),
    .msg_valid    (msg_valid),
    .msg_error    (msg_error),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef MSG_OUT_BUFFER_STATS_EN
    ,
    .msg_count    (msg_count),
    .err_count    (err_count),
    .drop_count   (drop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stats(input string tag, input int m, input int e, input int d);
`ifdef MSG_OUT_BUFFER_STATS_EN
    chk({tag, " msg_count"}, W'(msg_count), W'(m));
    chk({tag, " err_count"}, W'(err_count), W'(e));
    chk({tag, " drop_count"}, W'(drop_count), W'(d));
`endif
  endtask

  task automatic push(input logic [W-1:0] d);
    msg_data  = d;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
  endtask

  logic [W-1:0] exp3 [4];

  initial begin
    rst = 1'b1; msg_data = '0; msg_valid = 1'b0; msg_error = 1'b0;
    m_tready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset tvalid", W'(m_tvalid), W'(0));
    chk("reset fill", W'(fill_level), W'(0));
    chk("reset overflow", W'(overflow), W'(0));
    chk("reset tdata", m_tdata, '0);
    stats("reset", 0, 0, 0);

    // Single message, ready high.
    m_tready = 1'b1;
    push({32{8'hA5}});
    chk("single tvalid", W'(m_tvalid), W'(1));
    chk("single tdata", m_tdata, {32{8'hA5}});
    chk("single fill", W'(fill_level), W'(1));
    tick();
    chk("single fill after", W'(fill_level), W'(0));
    chk("single tvalid after", W'(m_tvalid), W'(0));

    // Back-pressure, fill, drop, then drain.
    m_tready = 1'b0;
    for (int k = 1; k <= 4; k++) push(W'(k));
    chk("bp fill", W'(fill_level), W'(4));
    chk("bp head", m_tdata, W'(1));
    push(W'(5));
    chk("drop fill", W'(fill_level), W'(4));
    chk("drop overflow", W'(overflow), W'(1));
    chk("drop head stable", m_tdata, W'(1));
    stats("drop", 5, 0, 1);
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain tvalid", W'(m_tvalid), W'(1));
      chk("drain tdata", m_tdata, W'(k));
      tick();
    end
    chk("drain empty", W'(m_tvalid), W'(0));
    chk("overflow sticky", W'(overflow), W'(1));
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("overflow cleared", W'(overflow), W'(0));
    stats("clr", 5, 0, 0);

    // Full with simultaneous read and write.
    m_tready = 1'b0;
    push(W'(6)); push(W'(7)); push(W'(8)); push(W'(10));
    chk("full fill", W'(fill_level), W'(4));
    m_tready = 1'b1;
    push(W'(9));
    chk("rw fill", W'(fill_level), W'(4));
    chk("rw overflow", W'(overflow), W'(0));
    chk("rw head", m_tdata, W'(7));
    exp3[0] = W'(7); exp3[1] = W'(8); exp3[2] = W'(10); exp3[3] = W'(9);
    for (int k = 0; k < 4; k++) begin
      chk("rw order", m_tdata, exp3[k]);
      tick();
    end
    chk("rw empty", W'(m_tvalid), W'(0));
    stats("rw", 10, 0, 0);

    // Errored message is discarded.
    msg_error = 1'b1;
    push(W'(8'hEE));
    msg_error = 1'b0;
    chk("err fill", W'(fill_level), W'(0));
    chk("err tvalid", W'(m_tvalid), W'(0));
    stats("err", 10, 1, 0);

    // Streaming with pointer wrap, one message per cycle.
    for (int i = 0; i < 10; i++) begin
      msg_data  = W'(256 + i);
      msg_valid = 1'b1;
      tick();
      chk("stream tvalid", W'(m_tvalid), W'(1));
      chk("stream tdata", m_tdata, W'(256 + i));
      chk("stream fill", W'(fill_level), W'(1));
    end
    msg_valid = 1'b0;
    tick();
    chk("stream end empty", W'(m_tvalid), W'(0));
    stats("stream", 20, 1, 0);

    // Drop while clearing: set wins; then read one to reach fill 3.
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) push(W'(8'h31 + k));
    overflow_clr = 1'b1;
    push(W'(8'h35));
    overflow_clr = 1'b0;
    chk("set wins overflow", W'(overflow), W'(1));
    stats("set wins", 24, 1, 1);
    m_tready = 1'b1; tick(); m_tready = 1'b0;
    chk("pre-rst fill", W'(fill_level), W'(3));
    chk("pre-rst head", m_tdata, W'(8'h32));

    // Reset mid-operation.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst tvalid", W'(m_tvalid), W'(0));
    chk("rst fill", W'(fill_level), W'(0));
    chk("rst overflow", W'(overflow), W'(0));
    chk("rst tdata", m_tdata, '0);
    stats("rst", 0, 0, 0);
    m_tready = 1'b1;
    push(W'(8'h77));
    chk("post-rst tvalid", W'(m_tvalid), W'(1));
    chk("post-rst tdata", m_tdata, W'(8'h77));
    tick();
    chk("post-rst empty", W'(m_tvalid), W'(0));
    stats("post-rst", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_out_buffer.md
Name: msg_out_buffer

Overview:
- Downstream stage of the message controller. Captures each completed message (msg_data / msg_valid / msg_error) into a small synchronous FIFO.
- Re-presents messages to the consumer on a valid/ready handshake, so back-pressure is absorbed; the controller has no ready input.
- Errored messages are discarded. Messages arriving while full are dropped and counted. A sticky overflow flag reports loss to software.

Parameters:
- MAX_MSG_BYTES, 32, message width in bytes; must match the controller.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- msg_data  input  8*MAX_MSG_BYTES  message payload from controller.
- msg_valid  input  1  one-cycle pulse; msg_data valid this cycle.
- msg_error  input  1  message discarded by controller this cycle.
- m_tvalid  output  1  head entry available.
- m_tready  input  1  consumer accepts head entry.
- m_tdata  output  8*MAX_MSG_BYTES  head entry payload.
- fill_level  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: at least one message dropped since reset or clear.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset: rst high at clk edge gives the following.
  - Pointers, fill_level, m_tvalid and overflow are 0; m_tdata is '0.
  - Counters (if compiled) are 0.
  - FIFO contents are not reset.
  - Reset mid-operation discards all stored messages; in-flight m_tvalid drops the next cycle.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write qualification:
  - wr_req = msg_valid && !msg_error.
  - msg_error high in the same cycle as msg_valid means the message is NOT written.
- Read: rd_fire = m_tvalid && m_tready.
- Write accept: wr_req && (!full || rd_fire).
  - Full plus simultaneous read means the write is accepted and occupancy stays DEPTH.
- Drop and overflow:
  - wr_req && full && !rd_fire means the message is dropped and overflow is set.
  - If overflow_clr and a new drop occur in the same cycle, set wins.
- Output timing:
  - m_tvalid = !empty; m_tdata = mem[rd_ptr index].
  - Both are registered from state; no combinational path from msg_* or m_tready to outputs.
  - Latency: a message written at edge N is visible with m_tvalid=1 after edge N.
  - Empty plus write: no bypass; output appears the cycle after the write.
- Handshake:
  - m_tdata is stable while m_tvalid && !m_tready.
  - m_tvalid never deasserts without rd_fire, except on rst.
- fill_level:
  - Increments on accepted write without read; decrements on read without write.
  - Unchanged on both or neither.
  - Range 0..DEPTH.
- Output state machine (2 states):
  - EMPTY: m_tvalid=0. Goes to HAVE on an accepted write.
  - HAVE: m_tvalid=1. Goes to EMPTY when rd_fire, fill_level==1 and no accepted write.
  - State must agree with the pointer-derived empty; verified by assertion.

Optional Feature:
- Macro: MSG_OUT_BUFFER_STATS_EN.
- Defined: adds outputs msg_count, err_count, drop_count, each CNT_WIDTH bits, saturating at all-ones.
  - msg_count: +1 per accepted write.
  - err_count: +1 per cycle with msg_error high.
  - drop_count: +1 per dropped message.
  - overflow_clr also zeroes drop_count.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package msg_pkg:
  - typedef msg_t (logic [8*MAX_MSG_BYTES-1:0] using package constant MSG_BYTES=32).
  - enum out_state_t {EMPTY, HAVE}.
  - function sat_inc.
- One natural sub-module: msg_fifo_mem, a DEPTH×msg_t register array with a single write port and an async read index.
- Pointer, flag and counter logic stays in msg_out_buffer.

Test Plan:
- Single message, empty buffer, m_tready=1: msg_data=32'hA5 pattern, msg_valid pulse → m_tvalid=1 next cycle with the same data; fill_level 1→0 after handshake.
- Back-pressure, m_tready=0: write 4 messages (0x1..0x4) → fill_level=4, head=0x1 stable. Write 0x5 → dropped, overflow=1, drop_count=1. Release ready → outputs 0x1..0x4 in order.
- Full plus simultaneous read and write: fill_level=4, m_tready=1, msg_valid with 0x9 → accepted, fill_level stays 4, overflow stays 0, 0x9 emerges last.
- Error discard: msg_valid=1 with msg_error=1 → no write, fill_level unchanged, err_count=1, msg_count unchanged.
- Wrap-around: stream 10 messages with m_tready=1, one per cycle → all received in order, pointers wrap, m_tvalid never glitches.
- Reset mid-operation: fill_level=3, assert rst one cycle → next cycle m_tvalid=0, fill_level=0, overflow=0, counters=0. A later write is delivered normally.
